median_window_3x3: RTL and testbench

- Upstream neighbour of the 9-input median stage.
- Accepts a raster-order 9-bit pixel stream and keeps two line buffers plus a 3x3 shift-register window.
- Presents nine window taps x_0..x_8 with a valid strobe; these feed the median stage's inputs directly.
- Emits a window only when all nine taps lie inside the image (no border padding).

---
 rtl/median_window_3x3.sv | 141 ++++++++++++++
 tb/tb_median_window_3x3.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/median_window_3x3.sv
// 3x3 sliding window over a raster pixel stream with two line buffers; emits only fully in-image windows.
// Optional MEDWIN_OUT_REG_EN adds a second output register stage (2-cycle latency).
module median_window_3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = 9,
    localparam int CW   = $clog2(IMG_W),
    localparam int RW   = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pix_in,
    input  logic          pix_valid,
    input  logic          sof,
    output logic [DW-1:0] x_0,
    output logic [DW-1:0] x_1,
    output logic [DW-1:0] x_2,
    output logic [DW-1:0] x_3,
    output logic [DW-1:0] x_4,
    output logic [DW-1:0] x_5,
    output logic [DW-1:0] x_6,
    output logic [DW-1:0] x_7,
    output logic [DW-1:0] x_8,
    output logic          win_valid,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          frame_done
);

    logic [CW-1:0] col, col_eff, col_nxt;
    logic [RW-1:0] row, row_eff, row_nxt;
    logic          last_col, last_row;

    logic [DW-1:0] lb0 [IMG_W];
    logic [DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] a, b;

    logic [8:0][DW-1:0] win;
    logic               s1_valid, s1_fd;
    logic [RW-1:0]      s1_row;
    logic [CW-1:0]      s1_col;

    logic [8:0][DW-1:0] o_win;
    logic               o_valid, o_fd;
    logic [RW-1:0]      o_row;
    logic [CW-1:0]      o_col;

    // sof forces the accepted pixel to (0,0) regardless of where the counters were
    always_comb begin
        col_eff  = sof ? '0 : col;
        row_eff  = sof ? '0 : row;
        last_col = (col_eff == CW'(IMG_W - 1));
        last_row = (row_eff == RW'(IMG_H - 1));
        col_nxt  = last_col ? '0 : col_eff + CW'(1);
        row_nxt  = row_eff;
        if (last_col)
            row_nxt = last_row ? '0 : row_eff + RW'(1);
    end

    assign a = lb1[col_eff];
    assign b = lb0[col_eff];

    // Line buffers are never reset: rows 0-1 cannot produce a valid window
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1[col_eff] <= b;
            lb0[col_eff] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            win      <= '0;
            s1_valid <= 1'b0;
            s1_fd    <= 1'b0;
            s1_row   <= '0;
            s1_col   <= '0;
        end else begin
            s1_valid <= 1'b0;
            s1_fd    <= 1'b0;
            if (pix_valid) begin
                col      <= col_nxt;
                row      <= row_nxt;
                win[0]   <= win[1];
                win[1]   <= win[2];
                win[2]   <= a;
                win[3]   <= win[4];
                win[4]   <= win[5];
                win[5]   <= b;
                win[6]   <= win[7];
                win[7]   <= win[8];
                win[8]   <= pix_in;
                s1_valid <= (row_eff >= RW'(2)) && (col_eff >= CW'(2));
                s1_row   <= row_eff - RW'(1);
                s1_col   <= col_eff - CW'(1);
                s1_fd    <= last_row && last_col;
            end
        end
    end

`ifdef MEDWIN_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_win   <= '0;
            o_valid <= 1'b0;
            o_fd    <= 1'b0;
            o_row   <= '0;
            o_col   <= '0;
        end else begin
            o_win   <= win;
            o_valid <= s1_valid;
            o_fd    <= s1_fd;
            o_row   <= s1_row;
            o_col   <= s1_col;
        end
    end
`else
    assign o_win   = win;
    assign o_valid = s1_valid;
    assign o_fd    = s1_fd;
    assign o_row   = s1_row;
    assign o_col   = s1_col;
`endif

    assign x_0        = o_win[0];
    assign x_1        = o_win[1];
    assign x_2        = o_win[2];
    assign x_3        = o_win[3];
    assign x_4        = o_win[4];
    assign x_5        = o_win[5];
    assign x_6        = o_win[6];
    assign x_7        = o_win[7];
    assign x_8        = o_win[8];
    assign win_valid  = o_valid;
    assign win_row    = o_row;
    assign win_col    = o_col;
    assign frame_done = o_fd;

endmodule

// File: tb/tb_median_window_3x3.sv
// Bench for median_window_3x3: directed 4x4 scenarios against a window table plus
// randomized streams checked against a frame-image reference model.
module tb_median_window_3x3;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 9;
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);
`ifdef MEDWIN_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0, rst = 1'b0, pix_valid = 1'b0, sof = 1'b0;
    logic [DW-1:0] pix_in = '0;
    logic [DW-1:0] x_0, x_1, x_2, x_3, x_4, x_5, x_6, x_7, x_8;
    logic win_valid, frame_done;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic [8:0][DW-1:0] dut_taps;

    always #5 clk = ~clk;

    median_window_3x3 #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .x_0(x_0), .x_1(x_1), .x_2(x_2), .x_3(x_3), .x_4(x_4),
        .x_5(x_5), .x_6(x_6), .x_7(x_7), .x_8(x_8),
        .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
        .frame_done(frame_done)
    );

    assign dut_taps = {x_8, x_7, x_6, x_5, x_4, x_3, x_2, x_1, x_0};

    typedef struct {
        bit                 vld;
        bit                 fd;
        bit                 chk_taps;
        bit                 chk_coord;
        logic [8:0][DW-1:0] taps;
        int                 crow;
        int                 ccol;
    } exp_t;

    typedef struct {
        int last_pix;
        int crow;
        int ccol;
        int t[9];
    } vec_t;

    int checks = 0;
    int failures = 0;
    int fd_cnt = 0;
    exp_t pipe[$];
    logic [8:0][DW-1:0] cap_taps[$];
    int cap_row[$];
    int cap_col[$];
    vec_t tbl[4];

    // Reference model: the frame as a 2D image plus the current raster position
    logic [DW-1:0] img[H][W];
    int m_r = 0, m_c = 0;
    bit known = 0, known_coord = 0;
    logic [8:0][DW-1:0] last_taps = '0;
    int last_row = 0, last_col = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit v, input bit s, input logic [DW-1:0] p, input bit r);
        exp_t e;
        pix_valid = v; sof = s; pix_in = p; rst = r;
        @(posedge clk);
        e = '{vld: 0, fd: 0, chk_taps: 0, chk_coord: 0, taps: '0, crow: 0, ccol: 0};
        if (r) begin
            m_r = 0; m_c = 0;
            known = 1; known_coord = 1; last_taps = '0; last_row = 0; last_col = 0;
            e.chk_taps = 1; e.chk_coord = 1;
            pipe.delete();
            for (int k = 0; k < LAT; k++) pipe.push_back(e);
        end else begin
            if (v) begin
                if (s) begin m_r = 0; m_c = 0; end
                img[m_r][m_c] = p;
                e.vld = (m_r >= 2 && m_c >= 2);
                e.fd  = (m_r == H-1 && m_c == W-1);
                if (e.vld) begin
                    for (int i = 0; i < 9; i++) last_taps[i] = img[m_r-2+i/3][m_c-2+i%3];
                    last_row = m_r - 1; last_col = m_c - 1;
                end
                known = e.vld; known_coord = e.vld;
                m_c++;
                if (m_c == W) begin m_c = 0; m_r = (m_r + 1) % H; end
            end
            e.chk_taps = known; e.chk_coord = known_coord;
            e.taps = last_taps; e.crow = last_row; e.ccol = last_col;
            pipe.push_back(e);
        end
        #1;
        e = pipe.pop_front();
        chk("win_valid", 32'(win_valid), 32'(e.vld));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
        if (e.chk_taps)
            for (int i = 0; i < 9; i++) chk($sformatf("tap%0d", i), 32'(dut_taps[i]), 32'(e.taps[i]));
        if (e.chk_coord) begin
            chk("win_row", 32'(win_row), 32'(e.crow));
            chk("win_col", 32'(win_col), 32'(e.ccol));
        end
        if (win_valid === 1'b1) begin
            cap_taps.push_back(dut_taps);
            cap_row.push_back(int'(win_row));
            cap_col.push_back(int'(win_col));
        end
        if (frame_done === 1'b1) fd_cnt++;
    endtask

    task automatic send_frame(input int npix, input bit gaps);
        for (int i = 0; i < npix; i++) begin
            step(1'b1, i == 0, DW'(i), 1'b0);
            if (gaps) step(1'b0, 1'b0, '0, 1'b0);
        end
    endtask

    task automatic clear_caps();
        cap_taps.delete(); cap_row.delete(); cap_col.delete(); fd_cnt = 0;
    endtask

    task automatic flush();
        for (int i = 0; i < LAT + 1; i++) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    // Compare captured windows against the table, nfr frames worth, plus frame_done count
    task automatic check_table(input string nm, input int nfr, input int nfd);
        chk({nm, "_win_count"}, 32'(cap_taps.size()), 32'(4*nfr));
        chk({nm, "_fd_count"}, 32'(fd_cnt), 32'(nfd));
        for (int i = 0; i < cap_taps.size() && i < 4*nfr; i++) begin
            chk({nm, "_row"}, 32'(cap_row[i]), 32'(tbl[i%4].crow));
            chk({nm, "_col"}, 32'(cap_col[i]), 32'(tbl[i%4].ccol));
            for (int k = 0; k < 9; k++)
                chk($sformatf("%s_w%0d_t%0d", nm, i, k), 32'(cap_taps[i][k]), 32'(tbl[i%4].t[k]));
        end
    endtask

    initial begin
        tbl[0] = '{10, 1, 1, '{0, 1, 2, 4, 5, 6, 8, 9, 10}};
        tbl[1] = '{11, 1, 2, '{1, 2, 3, 5, 6, 7, 9, 10, 11}};
        tbl[2] = '{14, 2, 1, '{4, 5, 6, 8, 9, 10, 12, 13, 14}};
        tbl[3] = '{15, 2, 2, '{5, 6, 7, 9, 10, 11, 13, 14, 15}};

        // Reset state
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);

        // Continuous full frame
        clear_caps();
        send_frame(16, 1'b0);
        flush();
        check_table("cont", 1, 1);

        // Same frame with a gap after every pixel
        clear_caps();
        send_frame(16, 1'b1);
        flush();
        check_table("gaps", 1, 1);

        // Back-to-back frames
        clear_caps();
        send_frame(16, 1'b0);
        send_frame(16, 1'b0);
        flush();
        check_table("b2b", 2, 2);

        // Frame aborted by sof at pixel 7
        clear_caps();
        send_frame(7, 1'b0);
        send_frame(16, 1'b0);
        flush();
        check_table("abort", 1, 1);

        // Reset after pixel 9, then a clean frame
        clear_caps();
        send_frame(10, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("rst_mid_valid", 32'(win_valid), 32'(0));
        chk("rst_mid_x8", 32'(x_8), 32'(0));
        clear_caps();
        send_frame(16, 1'b0);
        flush();
        check_table("rstmid", 1, 1);

        // Randomized streams: gaps, stray sof, ignored sof, occasional reset
        step(1'b1, 1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 3000; i++) begin
            bit rr, vv, ss;
            rr = ($urandom_range(0, 299) == 0);
            vv = ($urandom_range(0, 3) != 0);
            ss = ($urandom_range(0, 59) == 0);
            step(vv, ss, DW'($urandom), rr);
        end
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
